// File: rtl/led_pulse_stretcher.sv
// ----------------------------------------------------------------------------
// led_pulse_stretcher
//
// Turns single-cycle event strobes into human-visible LED blinks. Each blink
// holds the LED high for exactly ON_CYCLES clocks. It is then followed by at
// least GAP_CYCLES clocks of LED low. Events that arrive while a blink is in
// progress are queued in a saturating counter and replayed back to back.
//
// Ports
//   clk       in   1      system clock, all logic on posedge
//   rst       in   1      asynchronous, active-high reset
//   strobe    in   1      event pulse; every high cycle is one event
//   clr       in   1      synchronous clear of the overflow flag
//   led       out  1      registered LED drive, high = on
//   busy      out  1      registered, high while a blink or gap is running
//   pending   out  CNT_W  queued events not yet started
//   overflow  out  1      sticky flag: an event was dropped at saturation
// ----------------------------------------------------------------------------
module led_pulse_stretcher #(
    parameter int ON_CYCLES  = 5_000_000,
    parameter int GAP_CYCLES = 5_000_000,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic             clr,
    output logic             led,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP
    } state_t;

    state_t           state, state_nx;
    logic [TMR_W-1:0] timer, timer_nx;
    logic [CNT_W-1:0] pending_nx;
    logic             overflow_nx;
    logic             led_nx, busy_nx;

    logic can_start;     // FSM is in a cycle where a new blink may begin
    logic start;         // a blink begins on the coming edge
    logic take_pend;     // the started blink is paid for from the queue
    logic take_strobe;   // the started blink is paid for by the live strobe
    logic queue_strobe;  // the live strobe must go into the queue
    logic ovf_set;       // a queued strobe finds the counter full

    // Start decision and event accounting. The queue always has priority
    // over the live strobe. This preserves event order, and it means a strobe
    // arriving together with a queue-fed start is queued rather than lost.
    always_comb begin
        // NOTE: every signal gets a default before any branch. A path that
        // leaves a combinational output unassigned infers a latch.
        can_start    = (state == S_IDLE) || ((state == S_GAP) && (timer == '0));
        start        = can_start && (strobe || (pending != '0));
        take_pend    = start && (pending != '0);
        take_strobe  = start && (pending == '0);
        queue_strobe = strobe && !take_strobe;
        ovf_set      = 1'b0;
        pending_nx   = pending;

        if (queue_strobe && !take_pend) begin
            if (pending == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pending_nx = pending + CNT_W'(1);
            end
        end else if (take_pend && !queue_strobe) begin
            pending_nx = pending - CNT_W'(1);
        end
        // A queue-and-consume in the same cycle nets to zero, even when the
        // counter is full. That case is therefore not an overflow.

        // A set request wins over a clear request in the same cycle.
        overflow_nx = ovf_set ? 1'b1 : (clr ? 1'b0 : overflow);
    end

    // Next-state and timer logic
    always_comb begin
        state_nx = state;
        timer_nx = timer;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_ON;
                    timer_nx = ON_LOAD;
                end
            end
            S_ON: begin
                if (timer != '0) begin
                    timer_nx = timer - TMR_W'(1);
                end else begin
                    state_nx = S_GAP;
                    timer_nx = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (timer != '0) begin
                    timer_nx = timer - TMR_W'(1);
                end else if (start) begin
                    // Go straight back to ON, so back-to-back blinks keep a
                    // fixed ON+GAP period.
                    state_nx = S_ON;
                    timer_nx = ON_LOAD;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                timer_nx = '0;
            end
        endcase

        // Outputs come from the next state, so the registered copies line up
        // with the state register and do not lag it by one cycle.
        led_nx  = (state_nx == S_ON);
        busy_nx = (state_nx != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then sample their inputs at the same instant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            timer    <= '0;
            led      <= 1'b0;
            busy     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            led      <= led_nx;
            busy     <= busy_nx;
            pending  <= pending_nx;
            overflow <= overflow_nx;
        end
    end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// ----------------------------------------------------------------------------
// tb_led_pulse_stretcher
//
// Directed bench for led_pulse_stretcher with ON_CYCLES=3, GAP_CYCLES=2 and
// CNT_W=2. Each stimulus row drives strobe/clr for one cycle. The row also
// pushes the hand-computed {led, busy, pending, overflow} expected after the
// next clock edge. A monitor pops one entry per edge and compares it.
// ----------------------------------------------------------------------------
module tb_led_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       strobe = 1'b0;
    logic       clr = 1'b0;
    logic       led;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    typedef struct {
        logic [4:0] vec;   // {led, busy, pending[1:0], overflow}
        string      tag;
    } exp_t;

    exp_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;
    string cur_test = "init";
    int    row = 0;

    led_pulse_stretcher #(
        .ON_CYCLES (3),
        .GAP_CYCLES(2),
        .CNT_W     (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .strobe  (strobe),
        .clr     (clr),
        .led     (led),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic start_test(input string name);
        cur_test = name;
        row = 0;
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic drive(input logic s, input logic c, input logic l, input logic b,
                         input logic [1:0] p, input logic o);
        exp_t e;
        @(negedge clk);
        strobe = s;
        clr    = c;
        e.vec  = {l, b, p, o};
        e.tag  = $sformatf("%s row %0d (led,busy,pend,ovf)", cur_test, row);
        row++;
        sb_q.push_back(e);
    endtask

    // One full blink with pending constant at p: 3 rows with led high, then
    // 2 gap rows. The first row is the cycle that starts the blink.
    task automatic blink(input logic s0, input logic [1:0] p, input logic o);
        drive(s0,   1'b0, 1'b1, 1'b1, p, o);
        drive(1'b0, 1'b0, 1'b1, 1'b1, p, o);
        drive(1'b0, 1'b0, 1'b1, 1'b1, p, o);
        drive(1'b0, 1'b0, 1'b0, 1'b1, p, o);
        drive(1'b0, 1'b0, 1'b0, 1'b1, p, o);
    endtask

    task automatic idle_row();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    // Scoreboard monitor: samples 1 time unit after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.tag, {3'b000, led, busy, pending, overflow}, {3'b000, e.vec});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset led", {7'd0, led}, 8'd0);
        check("reset busy", {7'd0, busy}, 8'd0);
        check("reset pending", {6'd0, pending}, 8'd0);
        check("reset overflow", {7'd0, overflow}, 8'd0);
        rst = 1'b0;

        // 1: single strobe in IDLE
        start_test("single");
        blink(1'b1, 2'd0, 1'b0);
        idle_row();
        idle_row();

        // 2: three consecutive strobes -> three back-to-back blinks
        start_test("burst3");
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        blink(1'b0, 2'd1, 1'b0);
        blink(1'b0, 2'd0, 1'b0);
        idle_row();

        // 3: five strobes saturate the queue, then a clr pulse; 4 blinks total
        start_test("saturate");
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        blink(1'b0, 2'd1, 1'b0);
        blink(1'b0, 2'd0, 1'b0);
        idle_row();

        // 3b + 6: clr loses to an overflowing strobe; full queue plus a strobe
        // at gap expiry nets to zero without overflow
        start_test("clr_vs_set");
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        start_test("full_consume_queue");
        blink(1'b1, 2'd3, 1'b0);
        blink(1'b0, 2'd2, 1'b0);
        blink(1'b0, 2'd1, 1'b0);
        blink(1'b0, 2'd0, 1'b0);
        idle_row();

        // 4: strobe exactly at gap expiry with empty queue, busy never drops
        start_test("gap_expiry_strobe");
        blink(1'b1, 2'd0, 1'b0);
        blink(1'b1, 2'd0, 1'b0);
        idle_row();

        // 5: asynchronous reset mid-ON with pending=2
        start_test("async_reset");
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
        @(negedge clk);
        strobe = 1'b0;
        clr    = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("async_reset led", {7'd0, led}, 8'd0);
        check("async_reset busy", {7'd0, busy}, 8'd0);
        check("async_reset pending", {6'd0, pending}, 8'd0);
        check("async_reset overflow", {7'd0, overflow}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        start_test("post_reset");
        blink(1'b1, 2'd0, 1'b0);
        idle_row();
        idle_row();

        // Let the monitor drain the scoreboard (bounded)
        @(negedge clk);
        strobe = 1'b0;
        clr    = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        check("scoreboard drain", 8'(sb_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
